// File: rtl/mdu_iter.sv
// Iterative signed/unsigned multiply (MUL_STEP bits/cycle) and restoring divide (1 bit/cycle).
// Latency N+2 cycles from acceptance; stallreq_o holds EX until the result pulse, annul_i aborts.
module mdu_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 stallreq_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] N_MUL = CW'(WIDTH / MUL_STEP);
    localparam logic [CW-1:0] N_DIV = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     mag1_q, mag1_d;
    logic [WIDTH-1:0]     mag2_q, mag2_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg1_q, neg1_d;
    logic                 neg2_q, neg2_d;
    logic                 dz_q, dz_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    // Operand conditioning at acceptance: magnitudes and sign flags
    logic                 in_neg1, in_neg2, in_dz;
    logic [WIDTH-1:0]     abs1, abs2;

    assign in_neg1 = op_i[0] & opdata1_i[WIDTH-1];
    assign in_neg2 = op_i[0] & opdata2_i[WIDTH-1];
    assign abs1    = in_neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
    assign abs2    = in_neg2 ? (~opdata2_i + 1'b1) : opdata2_i;
    assign in_dz   = op_i[1] & (opdata2_i == '0);

    // Multiply step: acc = {partial hi, remaining multiplier bits}
    logic [WIDTH+MUL_STEP-1:0] pp;
    logic [WIDTH+MUL_STEP-1:0] hi_sum;
    logic [2*WIDTH-1:0]        mul_next;

    always_comb begin
        pp = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (acc_q[i]) begin
                pp = pp + ((WIDTH+MUL_STEP)'(mag1_q) << i);
            end
        end
        hi_sum   = (WIDTH+MUL_STEP)'(acc_q[2*WIDTH-1:WIDTH]) + pp;
        mul_next = (2*WIDTH)'({hi_sum, acc_q[WIDTH-1:0]} >> MUL_STEP);
    end

    // Divide step: acc = {partial remainder, dividend bits shifting into quotient}
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   div_next;

    always_comb begin
        rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, mag2_q};
        if (diff[WIDTH]) begin
            div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    // Sign fix-up; divide-by-zero returns all-ones quotient and the original dividend
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo, rem;
    logic [2*WIDTH-1:0]   fix_res;

    always_comb begin
        prod = (neg1_q ^ neg2_q) ? (~acc_q + 1'b1) : acc_q;
        quo  = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];
        if (dz_q) begin
            quo = '1;
            rem = neg1_q ? (~mag1_q + 1'b1) : mag1_q;
        end else begin
            if (neg1_q ^ neg2_q) begin
                quo = ~quo + 1'b1;
            end
            if (neg1_q) begin
                rem = ~rem + 1'b1;
            end
        end
        fix_res = op_q[1] ? {rem, quo} : prod;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mag1_d   = mag1_q;
        mag2_d   = mag2_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        dz_d     = dz_q;
        result_d = result_q;
        ready_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    op_d   = op_i;
                    mag1_d = abs1;
                    mag2_d = abs2;
                    neg1_d = in_neg1;
                    neg2_d = in_neg2;
                    dz_d   = in_dz;
                    acc_d  = {{WIDTH{1'b0}}, (op_i[1] ? abs1 : abs2)};
                    if (!op_i[1]) begin
                        cnt_d   = N_MUL;
                        state_d = S_RUN;
                    end else if (in_dz) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end else begin
                        cnt_d   = N_DIV;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = op_q[1] ? div_next : mul_next;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!annul_i) begin
                    result_d = fix_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                ready_o = !annul_i;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            mag1_q   <= '0;
            mag2_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mag1_q   <= mag1_d;
            mag2_q   <= mag2_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            dz_q     <= dz_d;
            result_q <= result_d;
        end
    end

    assign result_o   = result_q;
    assign busy_o     = (state_q != S_IDLE);
    assign stallreq_o = (state_q == S_RUN) || (state_q == S_FIX) ||
                        ((state_q == S_IDLE) && start_i && !annul_i);

endmodule
